dual_port_ram_ctrl: RTL and testbench

Parametrised synchronous true dual-port RAM. It replaces the fixed 4-bit-address, 8-bit, inout-data RAM with separate write and read buses per port, per-byte write enables and 1-cycle registered reads with a valid flag. It also adds deterministic collision handling and a post-reset clear sequencer. It sits between two independent masters, such as DMA and CPU, that share a scratch buffer.

---
 rtl/dual_port_ram_pkg.sv | 20 ++
 rtl/dpr_clear_seq.sv | 52 +++++
 rtl/dual_port_ram_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_dual_port_ram_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/dual_port_ram_pkg.sv
// Shared types and helpers for the dual-port RAM controller.
// Parity build option: DUAL_PORT_RAM_PARITY_EN.
package dual_port_ram_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Byte-lane count derived from the word width.
    function automatic int num_bytes_f(input int data_width);
        return data_width / 8;
    endfunction

    // Even parity bit: byte plus parity always holds an even number of ones.
    function automatic logic byte_parity_f(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/dpr_clear_seq.sv
// Post-reset clear sequencer: walks every word address once while busy,
// then parks in RUN until the next reset.
module dpr_clear_seq
    import dual_port_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  clr_we
);

    localparam logic [0:0] ST_CLEAR = CLEAR;
    localparam logic [0:0] ST_RUN   = RUN;

    logic [0:0]            state_r;
    logic [ADDR_WIDTH-1:0] cnt_r;

    // Clear FSM: the last counter value hands over to RUN on the same edge it is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_CLEAR;
            cnt_r   <= {ADDR_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    cnt_r <= cnt_r + ADDR_WIDTH'(1'b1);
                    if (cnt_r == {ADDR_WIDTH{1'b1}}) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_CLEAR;
                    end
                end
                ST_RUN: begin
                    state_r <= ST_RUN;
                    cnt_r   <= {ADDR_WIDTH{1'b0}};
                end
                default: begin
                    state_r <= ST_CLEAR;
                    cnt_r   <= {ADDR_WIDTH{1'b0}};
                end
            endcase
        end
    end

    assign busy     = (state_r == ST_CLEAR);
    assign clr_we   = (state_r == ST_CLEAR);
    assign clr_addr = cnt_r;

endmodule

// File: rtl/dual_port_ram_ctrl.sv
// True dual-port RAM with byte enables, registered reads, write/write collision
// flag and post-reset clear. Optional lane parity: DUAL_PORT_RAM_PARITY_EN.
module dual_port_ram_ctrl
    import dual_port_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    busy,
    input  logic                    cs_0,
    input  logic                    wr_0,
    input  logic [DATA_WIDTH/8-1:0] be_0,
    input  logic [ADDR_WIDTH-1:0]   addr_0,
    input  logic [DATA_WIDTH-1:0]   wdata_0,
    output logic [DATA_WIDTH-1:0]   rdata_0,
    output logic                    rvalid_0,
    output logic                    perr_0,
    input  logic                    cs_1,
    input  logic                    wr_1,
    input  logic [DATA_WIDTH/8-1:0] be_1,
    input  logic [ADDR_WIDTH-1:0]   addr_1,
    input  logic [DATA_WIDTH-1:0]   wdata_1,
    output logic [DATA_WIDTH-1:0]   rdata_1,
    output logic                    rvalid_1,
    output logic                    perr_1,
    output logic                    collision
);

    localparam int NUM_BYTES = num_bytes_f(DATA_WIDTH);
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    logic                  busy_s;
    logic                  clr_we_s;
    logic [ADDR_WIDTH-1:0] clr_addr_s;

    logic                  run_s;
    logic                  wr0_s;
    logic                  rd0_s;
    logic                  wr1_s;
    logic                  rd1_s;
    logic                  collide_s;

    logic                  w0_en_s;
    logic [ADDR_WIDTH-1:0] w0_addr_s;
    logic [DATA_WIDTH-1:0] w0_data_s;
    logic [NUM_BYTES-1:0]  w0_be_s;
    logic [NUM_BYTES-1:0]  w1_be_s;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic [DATA_WIDTH-1:0] rdata_0_r;
    logic [DATA_WIDTH-1:0] rdata_1_r;
    logic                  rvalid_0_r;
    logic                  rvalid_1_r;
    logic                  collision_r;

    dpr_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy_s),
        .clr_addr (clr_addr_s),
        .clr_we   (clr_we_s)
    );

    // Port request decode; nothing from the masters gets through while clearing or in reset.
    always_comb begin
        run_s = 1'b0;
        if (!busy_s && !rst) begin
            run_s = 1'b1;
        end else begin
            run_s = 1'b0;
        end
        wr0_s     = run_s & cs_0 & wr_0;
        rd0_s     = run_s & cs_0 & ~wr_0;
        wr1_s     = run_s & cs_1 & wr_1;
        rd1_s     = run_s & cs_1 & ~wr_1;
        collide_s = wr0_s & wr1_s & (addr_0 == addr_1) & (|(be_0 & be_1));
    end

    // Port-0 write path carries the clear writes while the sequencer is busy.
    always_comb begin
        w0_en_s   = 1'b0;
        w0_addr_s = {ADDR_WIDTH{1'b0}};
        w0_data_s = {DATA_WIDTH{1'b0}};
        w0_be_s   = {NUM_BYTES{1'b0}};
        if (clr_we_s) begin
            w0_en_s   = 1'b1;
            w0_addr_s = clr_addr_s;
            w0_data_s = {DATA_WIDTH{1'b0}};
            w0_be_s   = {NUM_BYTES{1'b1}};
        end else begin
            w0_en_s   = wr0_s;
            w0_addr_s = addr_0;
            w0_data_s = wdata_0;
            w0_be_s   = be_0;
        end
    end

    // Port 1 loses any lane that port 0 also writes at the same address.
    always_comb begin
        w1_be_s = be_1;
        if (w0_en_s && (w0_addr_s == addr_1)) begin
            w1_be_s = be_1 & ~w0_be_s;
        end else begin
            w1_be_s = be_1;
        end
    end

    // Word storage, written per byte lane from both ports.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (w0_en_s && w0_be_s[i]) begin
                mem_r[w0_addr_s][i*8 +: 8] <= w0_data_s[i*8 +: 8];
            end
            if (wr1_s && w1_be_s[i]) begin
                mem_r[addr_1][i*8 +: 8] <= wdata_1[i*8 +: 8];
            end
        end
    end

    // Registered read data and strobes; the read samples the pre-write word (read-first).
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_0_r   <= {DATA_WIDTH{1'b0}};
            rdata_1_r   <= {DATA_WIDTH{1'b0}};
            rvalid_0_r  <= 1'b0;
            rvalid_1_r  <= 1'b0;
            collision_r <= 1'b0;
        end else begin
            rvalid_0_r  <= rd0_s;
            rvalid_1_r  <= rd1_s;
            collision_r <= collide_s;
            if (rd0_s) begin
                rdata_0_r <= mem_r[addr_0];
            end
            if (rd1_s) begin
                rdata_1_r <= mem_r[addr_1];
            end
        end
    end

    assign busy      = busy_s;
    assign rdata_0   = rdata_0_r;
    assign rdata_1   = rdata_1_r;
    assign rvalid_0  = rvalid_0_r;
    assign rvalid_1  = rvalid_1_r;
    assign collision = collision_r;

`ifdef DUAL_PORT_RAM_PARITY_EN
    logic [NUM_BYTES-1:0] par_r [DEPTH];
    logic                 mism_0_s;
    logic                 mism_1_s;
    logic                 perr_0_r;
    logic                 perr_1_r;

    // Parity storage follows the data lane writes exactly.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (w0_en_s && w0_be_s[i]) begin
                par_r[w0_addr_s][i] <= byte_parity_f(w0_data_s[i*8 +: 8]);
            end
            if (wr1_s && w1_be_s[i]) begin
                par_r[addr_1][i] <= byte_parity_f(wdata_1[i*8 +: 8]);
            end
        end
    end

    // Recompute parity of the addressed word on each port.
    always_comb begin
        mism_0_s = 1'b0;
        mism_1_s = 1'b0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (byte_parity_f(mem_r[addr_0][i*8 +: 8]) != par_r[addr_0][i]) begin
                mism_0_s = 1'b1;
            end else begin
                mism_0_s = mism_0_s;
            end
            if (byte_parity_f(mem_r[addr_1][i*8 +: 8]) != par_r[addr_1][i]) begin
                mism_1_s = 1'b1;
            end else begin
                mism_1_s = mism_1_s;
            end
        end
    end

    // Parity error flags, aligned with rvalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            perr_0_r <= 1'b0;
            perr_1_r <= 1'b0;
        end else begin
            perr_0_r <= rd0_s & mism_0_s;
            perr_1_r <= rd1_s & mism_1_s;
        end
    end

    assign perr_0 = perr_0_r;
    assign perr_1 = perr_1_r;
`else
    assign perr_0 = 1'b0;
    assign perr_1 = 1'b0;
`endif

endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
// Scoreboard bench for dual_port_ram_ctrl (ADDR_WIDTH 4, DATA_WIDTH 16).
module tb_dual_port_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic        cs_0, wr_0, cs_1, wr_1;
    logic [1:0]  be_0, be_1;
    logic [3:0]  addr_0, addr_1;
    logic [15:0] wdata_0, wdata_1, rdata_0, rdata_1;
    logic        rvalid_0, rvalid_1, perr_0, perr_1, collision;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    dual_port_ram_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .busy(busy),
        .cs_0(cs_0), .wr_0(wr_0), .be_0(be_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .rdata_0(rdata_0), .rvalid_0(rvalid_0), .perr_0(perr_0),
        .cs_1(cs_1), .wr_1(wr_1), .be_1(be_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .rdata_1(rdata_1), .rvalid_1(rvalid_1), .perr_1(perr_1),
        .collision(collision)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rvalid pulse consumes one expected word from that port's queue.
    always @(negedge clk) begin
        if (rvalid_0 === 1'b1) begin
            if (q0.size() == 0) check("rvalid_0_unexpected", 32'd1, 32'd0);
            else check("rdata_0", {15'd0, perr_0, rdata_0}, {16'd0, q0.pop_front()});
        end
        if (rvalid_1 === 1'b1) begin
            if (q1.size() == 0) check("rvalid_1_unexpected", 32'd1, 32'd0);
            else check("rdata_1", {15'd0, perr_1, rdata_1}, {16'd0, q1.pop_front()});
        end
    end

    task automatic set0(input logic w, input logic [1:0] be, input logic [3:0] a,
                        input logic [15:0] d, input logic [15:0] exp);
        cs_0 = 1'b1; wr_0 = w; be_0 = be; addr_0 = a; wdata_0 = d;
        if (!w) q0.push_back(exp);
    endtask

    task automatic set1(input logic w, input logic [1:0] be, input logic [3:0] a,
                        input logic [15:0] d, input logic [15:0] exp);
        cs_1 = 1'b1; wr_1 = w; be_1 = be; addr_1 = a; wdata_1 = d;
        if (!w) q1.push_back(exp);
    endtask

    task automatic cycle();
        @(posedge clk); #1;
        cs_0 = 1'b0; cs_1 = 1'b0;
    endtask

    task automatic wait_clear(input string name);
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, n, 32'd16);
    endtask

    initial begin
        rst = 1'b1;
        cs_0 = 1'b0; wr_0 = 1'b0; be_0 = 2'b00; addr_0 = 4'd0; wdata_0 = 16'd0;
        cs_1 = 1'b0; wr_1 = 1'b0; be_1 = 2'b00; addr_1 = 4'd0; wdata_1 = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 32'd1);
        check("reset_rvalid", {rvalid_0, rvalid_1}, 32'd0);
        check("reset_collision", collision, 32'd0);
        check("reset_rdata", {rdata_0, rdata_1}, 32'd0);

        // Release reset with a write attempt held during the whole clear.
        rst = 1'b0;
        cs_0 = 1'b1; wr_0 = 1'b1; be_0 = 2'b11; addr_0 = 4'd3; wdata_0 = 16'hBEEF;
        wait_clear("clear_cycles");
        cs_0 = 1'b0;
        set0(1'b0, 2'b00, 4'd3, 16'h0, 16'h0000); cycle();

        // Basic write then cross-port read.
        set0(1'b1, 2'b11, 4'd2, 16'hA5A5, 16'h0); cycle();
        set1(1'b0, 2'b00, 4'd2, 16'h0, 16'hA5A5); cycle();

        // Byte enables.
        set0(1'b1, 2'b11, 4'd5, 16'h1234, 16'h0); cycle();
        set0(1'b1, 2'b01, 4'd5, 16'hFFFF, 16'h0); cycle();
        set0(1'b0, 2'b00, 4'd5, 16'h0, 16'h12FF); cycle();

        // Read-first on a same-address read/write.
        set0(1'b1, 2'b11, 4'd7, 16'h0F0F, 16'h0); cycle();
        set0(1'b1, 2'b11, 4'd7, 16'h00FF, 16'h0);
        set1(1'b0, 2'b00, 4'd7, 16'h0, 16'h0F0F); cycle();
        check("rw_no_collision", collision, 32'd0);
        set1(1'b0, 2'b00, 4'd7, 16'h0, 16'h00FF); cycle();

        // Write/write with full lane overlap: port 0 wins.
        set0(1'b1, 2'b11, 4'd9, 16'hAAAA, 16'h0);
        set1(1'b1, 2'b11, 4'd9, 16'h5555, 16'h0); cycle();
        check("ww_collision", collision, 32'd1);
        cycle();
        check("ww_collision_pulse", collision, 32'd0);
        set0(1'b0, 2'b00, 4'd9, 16'h0, 16'hAAAA); cycle();

        // Write/write with disjoint lanes merges and does not collide.
        set0(1'b1, 2'b10, 4'd9, 16'hAAAA, 16'h0);
        set1(1'b1, 2'b01, 4'd9, 16'h5555, 16'h0); cycle();
        check("ww_disjoint_no_collision", collision, 32'd0);
        set1(1'b0, 2'b00, 4'd9, 16'h0, 16'hAA55); cycle();

        // Simultaneous read/read and different-address writes.
        set0(1'b0, 2'b00, 4'd9, 16'h0, 16'hAA55);
        set1(1'b0, 2'b00, 4'd9, 16'h0, 16'hAA55); cycle();
        check("rr_no_collision", collision, 32'd0);
        set0(1'b1, 2'b11, 4'd10, 16'h1111, 16'h0);
        set1(1'b1, 2'b11, 4'd15, 16'h2222, 16'h0); cycle();
        set0(1'b0, 2'b00, 4'd15, 16'h0, 16'h2222);
        set1(1'b0, 2'b00, 4'd10, 16'h0, 16'h1111); cycle();
        set1(1'b1, 2'b00, 4'd10, 16'hDEAD, 16'h0); cycle();
        set0(1'b0, 2'b00, 4'd10, 16'h0, 16'h1111); cycle();

        // Reset mid-RUN while port 1 reads: the read is dropped.
        cs_1 = 1'b1; wr_1 = 1'b0; addr_1 = 4'd2;
        rst = 1'b1;
        cycle();
        check("midrun_rvalid_1", rvalid_1, 32'd0);
        check("midrun_busy", busy, 32'd1);
        rst = 1'b0;
        wait_clear("reclear_cycles");
        set0(1'b0, 2'b00, 4'd2, 16'h0, 16'h0000);
        set1(1'b0, 2'b00, 4'd9, 16'h0, 16'h0000); cycle();
        set1(1'b0, 2'b00, 4'd15, 16'h0, 16'h0000); cycle();

        repeat (3) @(posedge clk);
        #1;
        check("queues_drained", q0.size() + q1.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
